cursor_uart_rx: RTL

- Host-side receiver and decoder for the 6-byte Boreal Neuro-Core cursor packet: SYNC 0xAA, VER/BTN/SAFETY, DX, DY, FRAME_ID, CRC8.
- Deserialises 8N1 UART, hunts for sync, validates CRC8, version and inter-byte timing.
- Presents decoded cursor fields with a one-cycle valid strobe, plus error strobes and a frame-gap counter.
- Used in loopback benches and on the bridge FPGA that consumes the cursor stream.

---
 rtl/cursor_uart_rx.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cursor_uart_rx.sv
// Cursor packet receiver: 8N1 UART deserialiser, sync hunt, CRC8 / version /
// inter-byte timeout checks, decoded cursor fields and frame_id gap counter.
module cursor_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter logic [31:0] TIMEOUT_CLKS = 32'd21700
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              pkt_valid,
  output logic [1:0]        buttons,
  output logic [3:0]        safety_flags,
  output logic signed [7:0] dx,
  output logic signed [7:0] dy,
  output logic [7:0]        frame_id,
  output logic              crc_err,
  output logic              ver_err,
  output logic              frame_err,
  output logic              timeout_err,
  output logic [7:0]        gap_cnt
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [0:0] P_HUNT    = 1'b0;
  localparam logic [0:0] P_COLLECT = 1'b1;

  // One byte of CRC8 (poly 0x07), MSB first, no reflection.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Packet CRC: bytes 1..4 followed by one augmenting zero byte.
  function automatic logic [7:0] crc8_packet(input logic [5:1][7:0] pb);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 1; i <= 4; i++) c = crc8_byte(c, pb[i]);
    c = crc8_byte(c, 8'h00);
    return c;
  endfunction

  logic             rx_meta_q, rx_s_q;
  logic [1:0]       bstate_q, bstate_d;
  logic [15:0]      clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_stb_s, stop_bad_s;

  logic [0:0]       pstate_q, pstate_d;
  logic [2:0]       idx_q, idx_d;
  logic [5:1][7:0]  pkt_buf_q, pkt_buf_d;
  logic [31:0]      tmo_cnt_q, tmo_cnt_d;
  logic             eval_q, eval_d;
  logic             timeout_s;

  logic [7:0]       crc_s, next_id_s, gap_d;
  logic             crc_ok_s, ver_ok_s, good_s;

  logic             pkt_valid_q, crc_err_q, ver_err_q, frame_err_q, timeout_err_q;
  logic [1:0]       buttons_q;
  logic [3:0]       safety_q;
  logic [7:0]       dx_q, dy_q, frame_id_q, gap_cnt_q, prev_id_q;
  logic             have_prev_q;

  // Bit-level 8N1 receiver: start validation, mid-bit sampling, stop check.
  always_comb begin
    bstate_d   = bstate_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_stb_s = 1'b0;
    stop_bad_s = 1'b0;
    case (bstate_q)
      S_IDLE: begin
        if (rx_s_q == 1'b0) begin
          bstate_d  = S_START;
          clk_cnt_d = 16'd0;
        end else begin
          bstate_d  = S_IDLE;
        end
      end
      S_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = 16'd0;
          if (rx_s_q == 1'b0) begin
            bstate_d  = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            bstate_d  = S_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = 16'd0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bstate_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = 16'd0;
          bstate_d  = S_IDLE;
          if (rx_s_q == 1'b1) begin
            byte_stb_s = 1'b1;
          end else begin
            stop_bad_s = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      default: begin
        bstate_d  = S_IDLE;
        clk_cnt_d = 16'd0;
      end
    endcase
  end

  // Packet framing: sync hunt, byte collection, timeout and frame-error abort.
  always_comb begin
    pstate_d  = pstate_q;
    idx_d     = idx_q;
    pkt_buf_d = pkt_buf_q;
    tmo_cnt_d = tmo_cnt_q;
    eval_d    = 1'b0;
    timeout_s = 1'b0;
    case (pstate_q)
      P_HUNT: begin
        tmo_cnt_d = 32'd0;
        if (byte_stb_s && (shift_q == 8'hAA)) begin
          pstate_d = P_COLLECT;
          idx_d    = 3'd1;
        end else begin
          pstate_d = P_HUNT;
        end
      end
      P_COLLECT: begin
        if (stop_bad_s) begin
          // Frame error wins over a simultaneous timeout.
          pstate_d = P_HUNT;
          idx_d    = 3'd0;
        end else if (byte_stb_s) begin
          pkt_buf_d[idx_q] = shift_q;
          tmo_cnt_d        = 32'd0;
          if (idx_q == 3'd5) begin
            pstate_d = P_HUNT;
            idx_d    = 3'd0;
            eval_d   = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else if ((tmo_cnt_q + 32'd1) >= TIMEOUT_CLKS) begin
          timeout_s = 1'b1;
          pstate_d  = P_HUNT;
          idx_d     = 3'd0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
      end
      default: begin
        pstate_d = P_HUNT;
        idx_d    = 3'd0;
      end
    endcase
  end

  // Packet evaluation and frame_id continuity check.
  always_comb begin
    crc_s     = crc8_packet(pkt_buf_q);
    crc_ok_s  = (crc_s == pkt_buf_q[5]);
    ver_ok_s  = (pkt_buf_q[1][7:6] == 2'b01);
    good_s    = eval_q && crc_ok_s && ver_ok_s;
    next_id_s = prev_id_q + 8'd1;
    if (have_prev_q && (pkt_buf_q[4] != next_id_s) && (gap_cnt_q != 8'hFF)) begin
      gap_d = gap_cnt_q + 8'd1;
    end else begin
      gap_d = gap_cnt_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      bstate_q      <= S_IDLE;
      clk_cnt_q     <= 16'd0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      pstate_q      <= P_HUNT;
      idx_q         <= 3'd0;
      pkt_buf_q     <= '0;
      tmo_cnt_q     <= 32'd0;
      eval_q        <= 1'b0;
      pkt_valid_q   <= 1'b0;
      crc_err_q     <= 1'b0;
      ver_err_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      buttons_q     <= 2'b00;
      safety_q      <= 4'h0;
      dx_q          <= 8'h00;
      dy_q          <= 8'h00;
      frame_id_q    <= 8'h00;
      gap_cnt_q     <= 8'h00;
      prev_id_q     <= 8'h00;
      have_prev_q   <= 1'b0;
    end else begin
      rx_meta_q     <= rx;
      rx_s_q        <= rx_meta_q;
      bstate_q      <= bstate_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      pstate_q      <= pstate_d;
      idx_q         <= idx_d;
      pkt_buf_q     <= pkt_buf_d;
      tmo_cnt_q     <= tmo_cnt_d;
      eval_q        <= eval_d;
      pkt_valid_q   <= good_s;
      crc_err_q     <= eval_q && !crc_ok_s;
      ver_err_q     <= eval_q && crc_ok_s && !ver_ok_s;
      frame_err_q   <= stop_bad_s;
      timeout_err_q <= timeout_s;
      if (good_s) begin
        buttons_q   <= pkt_buf_q[1][5:4];
        safety_q    <= pkt_buf_q[1][3:0];
        dx_q        <= pkt_buf_q[2];
        dy_q        <= pkt_buf_q[3];
        frame_id_q  <= pkt_buf_q[4];
        gap_cnt_q   <= gap_d;
        prev_id_q   <= pkt_buf_q[4];
        have_prev_q <= 1'b1;
      end
    end
  end

  assign pkt_valid    = pkt_valid_q;
  assign buttons      = buttons_q;
  assign safety_flags = safety_q;
  assign dx           = dx_q;
  assign dy           = dy_q;
  assign frame_id     = frame_id_q;
  assign crc_err      = crc_err_q;
  assign ver_err      = ver_err_q;
  assign frame_err    = frame_err_q;
  assign timeout_err  = timeout_err_q;
  assign gap_cnt      = gap_cnt_q;

endmodule
